// File: rtl/date_counter.sv
// date_counter: running calendar register (BCD year, binary month/day).
// Advances one day per DAY_TICK and captures a sanitized date on LOAD.
// RESET is asynchronous and takes priority over LOAD, which takes
// priority over DAY_TICK.
module date_counter #(
   parameter logic [15:0] RST_YEAR  = 16'h2020,
   parameter logic [6:0]  RST_MONTH = 7'd1,
   parameter logic [6:0]  RST_DAY   = 7'd1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       LOAD,
   input  logic [3:0] SET_YEAR1000,
   input  logic [3:0] SET_YEAR100,
   input  logic [3:0] SET_YEAR10,
   input  logic [3:0] SET_YEAR1,
   input  logic [6:0] SET_MONTH,
   input  logic [6:0] SET_DAY,
   input  logic       DAY_TICK,
   output logic [3:0] YEAR1000,
   output logic [3:0] YEAR100,
   output logic [3:0] YEAR10,
   output logic [3:0] YEAR1,
   output logic [6:0] MONTH,
   output logic [6:0] DAY,
   output logic       LEAP,
   output logic       CLAMPED,
   output logic       YEAR_WRAP
);

   // A two-digit BCD value is divisible by 4 when an even tens digit pairs
   // with ones 0/4/8, or an odd tens digit pairs with ones 2/6.
   function automatic logic bcd2_div4(input logic [3:0] t, input logic [3:0] o);
      if (t[0]) return (o == 4'd2) || (o == 4'd6);
      else      return (o == 4'd0) || (o == 4'd4) || (o == 4'd8);
   endfunction

   // Gregorian leap rule on BCD digits; 0000 falls out as leap.
   function automatic logic leap_of(input logic [3:0] d3, input logic [3:0] d2,
                                    input logic [3:0] d1, input logic [3:0] d0);
      if ({d1, d0} == 8'h00) return bcd2_div4(d3, d2);
      else                   return bcd2_div4(d1, d0);
   endfunction

   function automatic logic [6:0] month_len(input logic [6:0] m, input logic lp);
      case (m)
         7'd2:                      return lp ? 7'd29 : 7'd28;
         7'd4, 7'd6, 7'd9, 7'd11:   return 7'd30;
         default:                   return 7'd31;
      endcase
   endfunction

   // yr_q[3] is the thousands digit, yr_q[0] the ones digit
   logic [3:0][3:0] yr_q, yr_d, yr_inc, set_yr;
   logic [6:0]      month_q, month_d, day_q, day_d;
   logic [6:0]      cur_len, set_month, set_day, set_len;
   logic            clamp_d, wrap_d, yr_clamp, carry;

   // BCD +1 across all four digits, resolved in one cycle
   always_comb begin
      yr_inc = yr_q;
      carry  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (yr_q[i] == 4'd9) begin
               yr_inc[i] = 4'd0;
            end else begin
               yr_inc[i] = yr_q[i] + 4'd1;
               carry     = 1'b0;
            end
         end
      end
   end

   // Sanitize the SET_* fields; leap and length come from the cleaned values
   always_comb begin
      set_yr   = {SET_YEAR1000, SET_YEAR100, SET_YEAR10, SET_YEAR1};
      yr_clamp = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (set_yr[i] > 4'd9) begin
            set_yr[i] = 4'd9;
            yr_clamp  = 1'b1;
         end
      end
      set_month = SET_MONTH;
      if (SET_MONTH == 7'd0 || SET_MONTH > 7'd12) set_month = 7'd1;
      set_len = month_len(set_month, leap_of(set_yr[3], set_yr[2], set_yr[1], set_yr[0]));
      set_day = SET_DAY;
      if (SET_DAY == 7'd0)         set_day = 7'd1;
      else if (SET_DAY > set_len)  set_day = set_len;
   end

   assign cur_len = month_len(month_q, LEAP);

   // Next-state select: LOAD wins over DAY_TICK; a colliding tick is dropped
   always_comb begin
      yr_d    = yr_q;
      month_d = month_q;
      day_d   = day_q;
      clamp_d = 1'b0;
      wrap_d  = 1'b0;
      if (LOAD) begin
         yr_d    = set_yr;
         month_d = set_month;
         day_d   = set_day;
         clamp_d = yr_clamp || (set_month != SET_MONTH) || (set_day != SET_DAY);
      end else if (DAY_TICK) begin
         if (day_q < cur_len) begin
            day_d = day_q + 7'd1;
         end else begin
            day_d = 7'd1;
            if (month_q == 7'd12) begin
               month_d = 7'd1;
               yr_d    = yr_inc;
               wrap_d  = carry;
            end else begin
               month_d = month_q + 7'd1;
            end
         end
      end
   end

   // Field registers and one-cycle status flags
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         yr_q      <= RST_YEAR;
         month_q   <= RST_MONTH;
         day_q     <= RST_DAY;
         CLAMPED   <= 1'b0;
         YEAR_WRAP <= 1'b0;
      end else begin
         yr_q      <= yr_d;
         month_q   <= month_d;
         day_q     <= day_d;
         CLAMPED   <= clamp_d;
         YEAR_WRAP <= wrap_d;
      end
   end

   assign YEAR1000 = yr_q[3];
   assign YEAR100  = yr_q[2];
   assign YEAR10   = yr_q[1];
   assign YEAR1    = yr_q[0];
   assign MONTH    = month_q;
   assign DAY      = day_q;
   assign LEAP     = leap_of(yr_q[3], yr_q[2], yr_q[1], yr_q[0]);

endmodule

// File: tb/tb_date_counter.sv
// Bench for date_counter: load table, calendar corner sequences, and a
// randomized run checked against an integer-calendar reference model.
module tb_date_counter;

   logic       CLK = 1'b0;
   logic       RESET, LOAD, DAY_TICK;
   logic [3:0] SET_YEAR1000, SET_YEAR100, SET_YEAR10, SET_YEAR1;
   logic [6:0] SET_MONTH, SET_DAY;
   logic [3:0] YEAR1000, YEAR100, YEAR10, YEAR1;
   logic [6:0] MONTH, DAY;
   logic       LEAP, CLAMPED, YEAR_WRAP;

   date_counter dut (
      .CLK(CLK), .RESET(RESET), .LOAD(LOAD),
      .SET_YEAR1000(SET_YEAR1000), .SET_YEAR100(SET_YEAR100),
      .SET_YEAR10(SET_YEAR10), .SET_YEAR1(SET_YEAR1),
      .SET_MONTH(SET_MONTH), .SET_DAY(SET_DAY), .DAY_TICK(DAY_TICK),
      .YEAR1000(YEAR1000), .YEAR100(YEAR100), .YEAR10(YEAR10), .YEAR1(YEAR1),
      .MONTH(MONTH), .DAY(DAY), .LEAP(LEAP), .CLAMPED(CLAMPED), .YEAR_WRAP(YEAR_WRAP)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   // reference model state: plain integer calendar
   int m_y, m_m, m_d;
   bit m_clamp, m_wrap;

   function automatic bit ref_leap(int y);
      return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
   endfunction

   function automatic int ref_len(int y, int m);
      if (m == 2) return ref_leap(y) ? 29 : 28;
      if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
      return 31;
   endfunction

   function automatic logic [15:0] to_bcd(int y);
      return {4'(y / 1000), 4'((y / 100) % 10), 4'((y / 10) % 10), 4'(y % 10)};
   endfunction

   function automatic logic [32:0] dut_vec();
      return {YEAR1000, YEAR100, YEAR10, YEAR1, MONTH, DAY, LEAP, CLAMPED, YEAR_WRAP};
   endfunction

   task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got y=%h m=%0d d=%0d leap=%b clamp=%b wrap=%b, want y=%h m=%0d d=%0d leap=%b clamp=%b wrap=%b",
                  nm, act[32:17], act[16:10], act[9:3], act[2], act[1], act[0],
                  exp[32:17], exp[16:10], exp[9:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic chk_model(input string nm);
      chk(nm, dut_vec(), {to_bcd(m_y), 7'(m_m), 7'(m_d), ref_leap(m_y), m_clamp, m_wrap});
   endtask

   // hand-written expectation, independent of the model
   task automatic expect_full(input string nm, input logic [15:0] y, input int m, input int d,
                              input bit lp, input bit c, input bit w);
      chk(nm, dut_vec(), {y, 7'(m), 7'(d), lp, c, w});
   endtask

   task automatic model_reset();
      m_y = 2020; m_m = 1; m_d = 1; m_clamp = 0; m_wrap = 0;
   endtask

   task automatic model_edge(input bit ld, input bit tk, input logic [15:0] sy, input int sm, input int sd);
      int dg[4];
      int len;
      m_clamp = 0;
      m_wrap  = 0;
      if (ld) begin
         for (int i = 0; i < 4; i++) begin
            dg[i] = int'(sy[i*4 +: 4]);
            if (dg[i] > 9) begin dg[i] = 9; m_clamp = 1; end
         end
         m_y = dg[3] * 1000 + dg[2] * 100 + dg[1] * 10 + dg[0];
         m_m = sm;
         if (sm == 0 || sm > 12) begin m_m = 1; m_clamp = 1; end
         len = ref_len(m_y, m_m);
         m_d = sd;
         if (sd == 0) begin m_d = 1; m_clamp = 1; end
         else if (sd > len) begin m_d = len; m_clamp = 1; end
      end else if (tk) begin
         if (m_d < ref_len(m_y, m_m)) m_d++;
         else begin
            m_d = 1;
            if (m_m == 12) begin
               m_m = 1;
               m_y = (m_y + 1) % 10000;
               if (m_y == 0) m_wrap = 1;
            end else m_m++;
         end
      end
   endtask

   // drive one cycle, let the edge happen, update model, check model
   task automatic cycle(input bit ld, input bit tk, input logic [15:0] sy, input int sm, input int sd);
      LOAD = ld; DAY_TICK = tk;
      {SET_YEAR1000, SET_YEAR100, SET_YEAR10, SET_YEAR1} = sy;
      SET_MONTH = 7'(sm); SET_DAY = 7'(sd);
      @(posedge CLK);
      model_edge(ld, tk, sy, sm, sd);
      #1;
      LOAD = 0; DAY_TICK = 0;
      chk_model("model");
   endtask

   typedef struct {
      logic [15:0] sy; int sm; int sd;
      logic [15:0] ey; int em; int ed; bit el; bit ec;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{16'h2023, 2, 30,  16'h2023, 2, 28, 0, 1};
      tbl[1] = '{16'h2024, 4, 31,  16'h2024, 4, 30, 1, 1};
      tbl[2] = '{16'h2021, 0, 0,   16'h2021, 1, 1,  0, 1};
      tbl[3] = '{16'h2021, 6, 15,  16'h2021, 6, 15, 0, 0};
      tbl[4] = '{16'h20A3, 13, 5,  16'h2093, 1, 5,  0, 1};
      tbl[5] = '{16'h1900, 2, 29,  16'h1900, 2, 28, 0, 1};
      tbl[6] = '{16'h2000, 2, 29,  16'h2000, 2, 29, 1, 0};
      tbl[7] = '{16'h9999, 12, 31, 16'h9999, 12, 31, 0, 0};

      RESET = 1; LOAD = 0; DAY_TICK = 0;
      {SET_YEAR1000, SET_YEAR100, SET_YEAR10, SET_YEAR1} = 16'h0;
      SET_MONTH = 0; SET_DAY = 0;
      model_reset();
      #12;
      expect_full("reset", 16'h2020, 1, 1, 1, 0, 0);
      RESET = 0;

      // load table with sanitization
      for (int i = 0; i < 8; i++) begin
         cycle(1, 0, tbl[i].sy, tbl[i].sm, tbl[i].sd);
         expect_full($sformatf("tbl%0d", i), tbl[i].ey, tbl[i].em, tbl[i].ed, tbl[i].el, tbl[i].ec, 0);
      end
      cycle(0, 0, 16'h0, 0, 0);
      expect_full("clamp_one_cycle", 16'h9999, 12, 31, 0, 0, 0);

      // month-end and leap sequences
      cycle(1, 0, 16'h2023, 2, 28); cycle(0, 1, 16'h0, 0, 0);
      expect_full("feb2023", 16'h2023, 3, 1, 0, 0, 0);
      cycle(1, 0, 16'h2024, 2, 28); cycle(0, 1, 16'h0, 0, 0);
      expect_full("feb2024_29", 16'h2024, 2, 29, 1, 0, 0);
      cycle(0, 1, 16'h0, 0, 0);
      expect_full("feb2024_mar", 16'h2024, 3, 1, 1, 0, 0);
      cycle(1, 0, 16'h1900, 2, 28); cycle(0, 1, 16'h0, 0, 0);
      expect_full("c1900", 16'h1900, 3, 1, 0, 0, 0);
      cycle(1, 0, 16'h2000, 2, 28); cycle(0, 1, 16'h0, 0, 0);
      expect_full("c2000", 16'h2000, 2, 29, 1, 0, 0);
      cycle(1, 0, 16'h2099, 12, 31); cycle(0, 1, 16'h0, 0, 0);
      expect_full("c2100", 16'h2100, 1, 1, 0, 0, 0);

      // full rollover
      cycle(1, 0, 16'h9999, 12, 31); cycle(0, 1, 16'h0, 0, 0);
      expect_full("wrap", 16'h0000, 1, 1, 1, 0, 1);
      cycle(0, 0, 16'h0, 0, 0);
      expect_full("wrap_drop", 16'h0000, 1, 1, 1, 0, 0);

      // held tick advances once per cycle
      cycle(1, 0, 16'h2022, 12, 30); cycle(0, 1, 16'h0, 0, 0); cycle(0, 1, 16'h0, 0, 0);
      expect_full("held_tick", 16'h2023, 1, 1, 0, 0, 0);

      // LOAD and DAY_TICK collision: tick discarded
      cycle(1, 0, 16'h2022, 5, 10);
      cycle(1, 1, 16'h2022, 8, 20);
      expect_full("collide", 16'h2022, 8, 20, 0, 0, 0);
      cycle(0, 1, 16'h0, 0, 0);
      expect_full("collide_next", 16'h2022, 8, 21, 0, 0, 0);

      // asynchronous reset mid-run
      cycle(1, 0, 16'h2031, 7, 15);
      #2 RESET = 1;
      model_reset();
      #2;
      expect_full("async_reset", 16'h2020, 1, 1, 1, 0, 0);
      RESET = 0;
      cycle(0, 1, 16'h0, 0, 0);
      expect_full("post_reset_tick", 16'h2020, 1, 2, 1, 0, 0);

      // randomized run against the model
      for (int n = 0; n < 600; n++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r == 0)
            cycle(1, $urandom_range(0, 1), 16'($urandom_range(0, 16'hFFFF)),
                  $urandom_range(0, 15), $urandom_range(0, 34));
         else if (r == 1)
            cycle(1, 0, 16'h9999, 12, $urandom_range(25, 31));
         else if (r == 2)
            cycle(1, 0, to_bcd($urandom_range(0, 9999)), $urandom_range(1, 12), $urandom_range(26, 31));
         else
            cycle(0, (r < 16), 16'h0, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/date_counter.md
# date_counter

Running calendar register for the term-project clock. Holds the current date, advances it by one day on each midnight pulse from the time-of-day block, and captures a new date from the date-set stage when the user leaves date-set mode. Sanitizes loaded dates, which the set stage can leave invalid (day 0, Feb 30, and similar). Outputs feed the display multiplexer and return to the date-set stage as its starting values.

## Interface
Parameters:
- RST_YEAR, 16'h2020, reset year as four BCD digits
- RST_MONTH, 1, reset month (binary)
- RST_DAY, 1, reset day (binary)

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- LOAD  in  1  one-cycle strobe; capture the SET_* inputs
- SET_YEAR1000, SET_YEAR100, SET_YEAR10, SET_YEAR1  in  4 each  BCD year digits from the date-set stage
- SET_MONTH  in  7  binary month from the date-set stage
- SET_DAY  in  7  binary day from the date-set stage
- DAY_TICK  in  1  one-cycle pulse at the 23:59:59 -> 00:00:00 rollover
- YEAR1000, YEAR100, YEAR10, YEAR1  out  4 each  current BCD year
- MONTH  out  7  current month, 1..12
- DAY  out  7  current day, 1..month length
- LEAP  out  1  combinational; current year is a leap year
- CLAMPED  out  1  registered; high for one cycle after a LOAD that altered any field
- YEAR_WRAP  out  1  registered; high for one cycle after the 9999-12-31 -> 0000-01-01 rollover

## Operation
- Leap rule on BCD digits:
  - Leap if YEAR10:YEAR1 is nonzero and divisible by 4.
  - If YEAR10:YEAR1 = 00, leap only if YEAR1000:YEAR100 is divisible by 4.
  - Year 0000 is leap.
- Month length: 31 for months 1, 3, 5, 7, 8, 10, 12; 30 for 4, 6, 9, 11; 29 or 28 for month 2 by LEAP.
- DAY_TICK advance:
  - If DAY < month length, DAY increments.
  - Otherwise DAY <= 1 and MONTH increments.
  - From MONTH = 12, MONTH <= 1 and the year increments in BCD, with each digit wrapping 9 -> 0 and carrying to the next digit.
  - 9999 wraps to 0000 and sets YEAR_WRAP.
- LOAD sanitization, applied in this order. Leap and month length are evaluated on the sanitized year and month, not on current state.
  1. Any SET year digit > 9 is replaced by 9.
  2. SET_MONTH of 0 or > 12 is replaced by 1.
  3. SET_DAY of 0 is replaced by 1. SET_DAY greater than the month length is replaced by the month length.
  4. CLAMPED is set if any replacement occurred.
- Priority: RESET > LOAD > DAY_TICK. When LOAD and DAY_TICK arrive in the same cycle, the tick is discarded and not deferred.
- No FSM beyond the field registers and the carry chain. All three update conditions are decoded from the LOAD/DAY_TICK inputs each cycle.

## Timing
- Reset: year = RST_YEAR digits, MONTH = RST_MONTH, DAY = RST_DAY, CLAMPED = 0, YEAR_WRAP = 0. With the default parameters, LEAP = 1 (2020).
- Reset takes effect immediately and asynchronously, including in the middle of a LOAD. The first post-reset edge acts on LOAD/DAY_TICK normally.
- LOAD or DAY_TICK sampled on rising edge N: new date visible after edge N; CLAMPED and YEAR_WRAP are high for the cycle after edge N only.
- LEAP follows the registered year combinationally, with zero latency from the year registers.
- SET_* inputs must be stable only in the cycle where LOAD is high.
- DAY_TICK held high for k cycles advances the date k days. Upstream is responsible for single-cycle pulses.
- Full carry (day -> month -> four year digits) completes within one cycle, with no multi-cycle ripple.

## Test plan
- Reset with defaults -> 2020-01-01, LEAP = 1, CLAMPED = 0, YEAR_WRAP = 0. Assert RESET mid-run at 2031-07-15 -> immediate return to 2020-01-01.
- Load 2023-02-28, then one DAY_TICK -> 2023-03-01, LEAP = 0. Load 2024-02-28, then two ticks -> 2024-02-29, then 2024-03-01.
- Century rule:
  - Load 1900-02-28, tick -> 1900-03-01.
  - Load 2000-02-28, tick -> 2000-02-29.
  - Load 2099-12-31, tick -> 2100-01-01, LEAP = 0.
- Load 9999-12-31, tick -> 0000-01-01, YEAR_WRAP = 1 for exactly one cycle, LEAP = 1.
- Sanitization:
  - Load 2023-02-30 -> 2023-02-28, CLAMPED = 1 for one cycle.
  - Load 2024-04-31 -> 2024-04-30, CLAMPED = 1.
  - Load 2021-00-00 -> 2021-01-01, CLAMPED = 1.
  - Load 2021-06-15 -> unchanged, CLAMPED = 0.
- Collision: at 2022-05-10, assert LOAD = 2022-08-20 together with DAY_TICK -> 2022-08-20, not 08-21. Next tick -> 2022-08-21.
